traffic_density_encoder: RTL and testbench

//  Produces the per-lane traffic-level flags L[2:0]/H[2:0] that the traffic light controller consumes.
//  - Each of 3 lane inputs carries a raw loop-detector signal (one high pulse per vehicle).
//  - Per lane: synchronise, debounce, count vehicles over a window of WINDOW_SEC seconds.
//  - The window is timed by the 1 Hz tick from the second divider.
//  - At each window close: classify each lane low/high and update L/H for the whole next window.

---
 rtl/traffic_density_encoder.sv | 185 ++++++++++++++++++
 tb/tb_traffic_density_encoder.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_density_encoder.sv
// Per-lane vehicle counting over a sec_tick-timed window, classified into light (L) / heavy (H) flags.
// Detector inputs are synchronised and debounced before counting; counters saturate instead of wrapping.
module traffic_density_encoder #(
   parameter int DEB_CYCLES = 4,
   parameter int WINDOW_SEC = 10,
   parameter int LOW_TH     = 2,
   parameter int HIGH_TH    = 8,
   parameter int CNT_W      = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sec_tick,
   input  logic [2:0] car_det,
   output logic [2:0] L,
   output logic [2:0] H,
   output logic       valid,
   output logic [2:0] sat
);

   localparam int DC_W  = $clog2(DEB_CYCLES + 1);
   localparam int WIN_W = (WINDOW_SEC > 1) ? $clog2(WINDOW_SEC) : 1;

   localparam logic [DC_W-1:0]  DC_ONE   = DC_W'(1);
   localparam logic [DC_W-1:0]  DC_MAX   = DC_W'(DEB_CYCLES);
   localparam logic [WIN_W-1:0] WIN_ZERO = WIN_W'(0);
   localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_SEC - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] LOW_C    = CNT_W'(LOW_TH);
   localparam logic [CNT_W-1:0] HIGH_C   = CNT_W'(HIGH_TH);

   typedef enum logic [1:0] {
      D_LOW  = 2'd0,
      D_RISE = 2'd1,
      D_HIGH = 2'd2,
      D_FALL = 2'd3
   } deb_state_t;

   // Saturating increment: holds at all-ones instead of wrapping to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         sat_inc = v;
      end else begin
         sat_inc = v + CNT_ONE;
      end
   endfunction

   logic [2:0]       sync1_r;
   logic [2:0]       sync2_r;
   logic [2:0]       inc_s;
   logic             close_s;
   logic [WIN_W-1:0] win_r;
   logic [CNT_W-1:0] cnt_r [3];
   logic [2:0]       sat_int_r;
   logic [2:0]       l_r;
   logic [2:0]       h_r;
   logic [2:0]       sat_r;
   logic             valid_r;

   // Two-flop synchroniser for the asynchronous detector levels
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 3'b000;
         sync2_r <= 3'b000;
      end else begin
         sync1_r <= car_det;
         sync2_r <= sync1_r;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_lane
      deb_state_t      state_r;
      logic [DC_W-1:0] dc_r;

      // Debounce FSM: a level change is accepted after DEB_CYCLES+1 equal samples
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_r <= D_LOW;
            dc_r    <= {DC_W{1'b0}};
         end else begin
            case (state_r)
               D_LOW: begin
                  if (sync2_r[i]) begin
                     state_r <= D_RISE;
                     dc_r    <= DC_ONE;
                  end
               end
               D_RISE: begin
                  if (!sync2_r[i]) begin
                     state_r <= D_LOW;
                  end else if (dc_r == DC_MAX) begin
                     state_r <= D_HIGH;
                  end else begin
                     dc_r <= dc_r + DC_ONE;
                  end
               end
               D_HIGH: begin
                  if (!sync2_r[i]) begin
                     state_r <= D_FALL;
                     dc_r    <= DC_ONE;
                  end
               end
               D_FALL: begin
                  if (sync2_r[i]) begin
                     state_r <= D_HIGH;
                  end else if (dc_r == DC_MAX) begin
                     state_r <= D_LOW;
                  end else begin
                     dc_r <= dc_r + DC_ONE;
                  end
               end
               default: begin
                  state_r <= D_LOW;
                  dc_r    <= {DC_W{1'b0}};
               end
            endcase
         end
      end

      // The accepted rising edge is the vehicle event
      assign inc_s[i] = (state_r == D_RISE) && sync2_r[i] && (dc_r == DC_MAX);
   end

   assign close_s = sec_tick && (win_r == WIN_LAST);

   // Window position, advanced by each high clock of sec_tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_r <= WIN_ZERO;
      end else if (sec_tick) begin
         win_r <= close_s ? WIN_ZERO : (win_r + WIN_ONE);
      end else begin
         win_r <= win_r;
      end
   end

   // Lane counters; an event on the closing edge belongs to the new window
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            cnt_r[k] <= CNT_ZERO;
         end
         sat_int_r <= 3'b000;
      end else begin
         for (int k = 0; k < 3; k++) begin
            if (close_s) begin
               cnt_r[k]     <= inc_s[k] ? CNT_ONE : CNT_ZERO;
               sat_int_r[k] <= 1'b0;
            end else if (inc_s[k]) begin
               cnt_r[k] <= sat_inc(cnt_r[k]);
               if (cnt_r[k] == CNT_MAX) begin
                  sat_int_r[k] <= 1'b1;
               end
            end
         end
      end
   end

   // Classification registers, refreshed only when a window closes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         l_r     <= 3'b000;
         h_r     <= 3'b000;
         sat_r   <= 3'b000;
         valid_r <= 1'b0;
      end else begin
         valid_r <= close_s;
         if (close_s) begin
            for (int k = 0; k < 3; k++) begin
               l_r[k] <= (cnt_r[k] <= LOW_C);
               h_r[k] <= (cnt_r[k] >= HIGH_C);
            end
            sat_r <= sat_int_r;
         end
      end
   end

   assign L     = l_r;
   assign H     = h_r;
   assign sat   = sat_r;
   assign valid = valid_r;

endmodule

// File: tb/tb_traffic_density_encoder.sv
// Bench for traffic_density_encoder: run-length/true-count reference model checked every cycle,
// plus directed scenarios with literal expected flags.
module tb_traffic_density_encoder;

   localparam int DEB     = 4;
   localparam int WIN     = 10;
   localparam int LOW     = 2;
   localparam int HIGH    = 8;
   localparam int CW      = 6;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic       clk;
   logic       reset;
   logic       sec_tick;
   logic [2:0] car_det;
   logic [2:0] L;
   logic [2:0] H;
   logic       valid;
   logic [2:0] sat;

   int n_cmp;
   int n_err;

   traffic_density_encoder #(
      .DEB_CYCLES (DEB),
      .WINDOW_SEC (WIN),
      .LOW_TH     (LOW),
      .HIGH_TH    (HIGH),
      .CNT_W      (CW)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .sec_tick (sec_tick),
      .car_det  (car_det),
      .L        (L),
      .H        (H),
      .valid    (valid),
      .sat      (sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: true vehicle counts and run lengths of the 2-cycle-delayed detector samples
   int         m_s1 [3];
   int         m_s2 [3];
   int         m_last [3];
   int         m_run [3];
   int         m_acc [3];
   int         m_cnt [3];
   int         m_win;
   logic [2:0] e_L;
   logic [2:0] e_H;
   logic [2:0] e_sat;
   logic       e_valid;

   always @(posedge clk or negedge reset) begin : model
      bit close_v;
      int obs_v;
      int run_v;
      int acc_v;
      int ev_v;
      int capped_v;
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            m_s1[i]   <= 0;
            m_s2[i]   <= 0;
            m_last[i] <= 0;
            m_run[i]  <= 0;
            m_acc[i]  <= 0;
            m_cnt[i]  <= 0;
         end
         m_win   <= 0;
         e_L     <= 3'b000;
         e_H     <= 3'b000;
         e_sat   <= 3'b000;
         e_valid <= 1'b0;
      end else begin
         close_v = sec_tick && (m_win == WIN - 1);
         for (int i = 0; i < 3; i++) begin
            obs_v = m_s2[i];
            run_v = (obs_v == m_last[i]) ? m_run[i] + 1 : 1;
            acc_v = m_acc[i];
            ev_v  = 0;
            if (obs_v != acc_v && run_v == DEB + 1) begin
               acc_v = obs_v;
               ev_v  = obs_v;
            end
            m_last[i] <= obs_v;
            m_run[i]  <= run_v;
            m_acc[i]  <= acc_v;
            if (close_v) begin
               capped_v = (m_cnt[i] > CNT_MAX) ? CNT_MAX : m_cnt[i];
               e_L[i]   <= (capped_v <= LOW);
               e_H[i]   <= (capped_v >= HIGH);
               e_sat[i] <= (m_cnt[i] > CNT_MAX);
               m_cnt[i] <= ev_v;
            end else begin
               m_cnt[i] <= m_cnt[i] + ev_v;
            end
            m_s2[i] <= m_s1[i];
            m_s1[i] <= int'(car_det[i]);
         end
         e_valid <= close_v;
         if (sec_tick) begin
            m_win <= close_v ? 0 : m_win + 1;
         end
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (reset) begin
         check("model_L", L, e_L);
         check("model_H", H, e_H);
         check("model_sat", sat, e_sat);
         check("model_valid", valid, e_valid);
      end
   end

   task automatic do_tick();
      @(negedge clk) sec_tick = 1'b1;
      @(negedge clk) sec_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) do_tick();
   endtask

   task automatic pulses(input int lane, input int n, input int len);
      repeat (n) begin
         car_det[lane] = 1'b1;
         repeat (len) @(negedge clk);
         car_det[lane] = 1'b0;
         repeat (len) @(negedge clk);
      end
   endtask

   task automatic drain();
      repeat (10) @(negedge clk);
   endtask

   task automatic expect_close(input string tag, input logic [2:0] l_e, input logic [2:0] h_e,
                               input logic [2:0] s_e);
      check({tag, "_valid"}, valid, 1'b1);
      check({tag, "_L"}, L, l_e);
      check({tag, "_H"}, H, h_e);
      check({tag, "_sat"}, sat, s_e);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      reset    = 1'b0;
      sec_tick = 1'b0;
      car_det  = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      check("rst_L", L, 3'b000);
      check("rst_H", H, 3'b000);
      check("rst_valid", valid, 1'b0);
      check("rst_sat", sat, 3'b000);
      @(negedge clk) reset = 1'b1;

      // Idle window
      drain();
      ticks(WIN);
      expect_close("t1", 3'b111, 3'b000, 3'b000);
      @(negedge clk);
      check("t1_valid_drop", valid, 1'b0);

      // Lane0 heavy, lane1 medium, lane2 empty
      pulses(0, 8, 10);
      pulses(1, 3, 10);
      drain();
      ticks(WIN);
      expect_close("t2", 3'b100, 3'b001, 3'b000);

      // Short glitches ignored, two clean pulses on lane1
      for (int g = 0; g < 20; g++) begin
         pulses(1, 1, 3);
      end
      pulses(1, 2, 10);
      drain();
      ticks(WIN);
      expect_close("t3", 3'b111, 3'b000, 3'b000);

      // Pulse accepted on the very edge that closes the window
      pulses(0, 7, 10);
      drain();
      ticks(WIN - 1);
      @(negedge clk) car_det[0] = 1'b1;
      repeat (6) @(negedge clk);
      sec_tick = 1'b1;
      @(negedge clk) sec_tick = 1'b0;
      expect_close("t4a", 3'b110, 3'b000, 3'b000);
      repeat (4) @(negedge clk);
      car_det[0] = 1'b0;
      drain();
      pulses(0, 7, 10);
      drain();
      ticks(WIN);
      expect_close("t4b", 3'b110, 3'b001, 3'b000);

      // Saturation on lane2, then clearing of sat after an idle window
      pulses(2, 70, 6);
      drain();
      ticks(WIN);
      expect_close("t5a", 3'b011, 3'b100, 3'b100);
      ticks(WIN);
      expect_close("t5b", 3'b111, 3'b000, 3'b000);

      // Asynchronous reset mid-window with flags set
      pulses(0, 8, 10);
      drain();
      ticks(WIN);
      expect_close("t6a", 3'b110, 3'b001, 3'b000);
      ticks(4);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("t6_rst_L", L, 3'b000);
      check("t6_rst_H", H, 3'b000);
      check("t6_rst_valid", valid, 1'b0);
      check("t6_rst_sat", sat, 3'b000);
      @(negedge clk) reset = 1'b1;
      ticks(WIN - 1);
      check("t6_no_early_valid", valid, 1'b0);
      do_tick();
      expect_close("t6b", 3'b111, 3'b000, 3'b000);

      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
